// File: rtl/flip_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flip_pkg                                                         |
// | Shared mode/state encodings for the rectangle flip engine.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package flip_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_H    = 2'b01,
        MODE_V    = 2'b10,
        MODE_BOTH = 2'b11
    } flip_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RD_A  = 3'd2,
        RD_B  = 3'd3,
        WR_A  = 3'd4,
        WR_B  = 3'd5,
        DONE  = 3'd6
    } flip_state_t;

    // Cycles spent on one swapped pair (RD_A, RD_B, WR_A, WR_B).
    localparam int PAIR_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/flip_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flip_addr_gen                                                    |
// | Combinational A/B element addresses for the current pair.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module flip_addr_gen
    import flip_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 2,
    parameter int COLS   = 4
)(
    input  logic [ADDR_W-1:0] i_base,
    input  logic [IDX_W-1:0]  i_r1,
    input  logic [IDX_W-1:0]  i_r2,
    input  logic [IDX_W-1:0]  i_c1,
    input  logic [IDX_W-1:0]  i_c2,
    input  logic [IDX_W-1:0]  i_i,
    input  logic [IDX_W-1:0]  i_j,
    input  flip_mode_t        i_mode,
    output logic [ADDR_W-1:0] o_addr_a,
    output logic [ADDR_W-1:0] o_addr_b
);

    localparam logic [ADDR_W-1:0] c_COLS = ADDR_W'(COLS);

    logic [IDX_W-1:0] w_row_a;
    logic [IDX_W-1:0] w_col_a;
    logic [IDX_W-1:0] w_row_b;
    logic [IDX_W-1:0] w_col_b;

    always_comb begin
        w_row_a = i_r1 + i_i;
        w_col_a = i_c1 + i_j;
        w_row_b = w_row_a;
        w_col_b = w_col_a;
        case (i_mode)
            MODE_H:    w_col_b = i_c2 - i_j;
            MODE_V:    w_row_b = i_r2 - i_i;
            MODE_BOTH: begin
                w_row_b = i_r2 - i_i;
                w_col_b = i_c2 - i_j;
            end
            default: ;
        endcase
    end

    // Address arithmetic deliberately wraps modulo 2^ADDR_W.
    assign o_addr_a = i_base + ADDR_W'(w_row_a) * c_COLS + ADDR_W'(w_col_a);
    assign o_addr_b = i_base + ADDR_W'(w_row_b) * c_COLS + ADDR_W'(w_col_b);

endmodule
`default_nettype wire

// File: rtl/rect_flip_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rect_flip_engine                                                 |
// | In-place H/V/180-degree rectangle flip over a single BRAM port.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rect_flip_engine
    import flip_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int IDX_W      = (((ROWS > COLS) ? ROWS : COLS) > 2) ?
                               $clog2((ROWS > COLS) ? ROWS : COLS) : 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [IDX_W-1:0]      r1,
    input  logic [IDX_W-1:0]      r2,
    input  logic [IDX_W-1:0]      c1,
    input  logic [IDX_W-1:0]      c2,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int CNT_W = $clog2(ROWS * COLS + 1);
    localparam logic [CNT_W-1:0] c_ROWS = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] c_COLS = CNT_W'(COLS);

    flip_state_t           r_state;
    flip_state_t           w_next;
    logic [ADDR_W-1:0]     r_base;
    logic [IDX_W-1:0]      r_r1;
    logic [IDX_W-1:0]      r_r2;
    logic [IDX_W-1:0]      r_c1;
    logic [IDX_W-1:0]      r_c2;
    logic [IDX_W-1:0]      r_i;
    logic [IDX_W-1:0]      r_j;
    flip_mode_t            r_mode;
    logic [CNT_W-1:0]      r_k;
    logic [CNT_W-1:0]      r_pairs;
    logic [DATA_WIDTH-1:0] r_a_val;
    logic                  r_error;

    logic [CNT_W-1:0]      w_h;
    logic [CNT_W-1:0]      w_w;
    logic [CNT_W-1:0]      w_pairs;
    logic                  w_arg_err;
    logic                  w_last_pair;
    logic                  w_row_wrap;
    logic [ADDR_W-1:0]     w_addr_a;
    logic [ADDR_W-1:0]     w_addr_b;

    flip_addr_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .COLS   (COLS)
    ) u_addr_gen (
        .i_base   (r_base),
        .i_r1     (r_r1),
        .i_r2     (r_r2),
        .i_c1     (r_c1),
        .i_c2     (r_c2),
        .i_i      (r_i),
        .i_j      (r_j),
        .i_mode   (r_mode),
        .o_addr_a (w_addr_a),
        .o_addr_b (w_addr_b)
    );

    // Rectangle size and pair count; only meaningful when the bounds are valid.
    assign w_h = CNT_W'(r_r2) - CNT_W'(r_r1) + CNT_W'(1);
    assign w_w = CNT_W'(r_c2) - CNT_W'(r_c1) + CNT_W'(1);

    assign w_arg_err = (r_r1 > r_r2) || (r_c1 > r_c2) ||
                       (CNT_W'(r_r2) >= c_ROWS) || (CNT_W'(r_c2) >= c_COLS);

    always_comb begin
        w_pairs = '0;
        case (r_mode)
            MODE_H:    w_pairs = w_h * (w_w >> 1);
            MODE_V:    w_pairs = (w_h >> 1) * w_w;
            MODE_BOTH: w_pairs = (w_h * w_w) >> 1;
            default:   w_pairs = '0;
        endcase
    end

    assign w_last_pair = (r_k == r_pairs - CNT_W'(1));

    // H mode only walks the left half of each row; the column wrap happens
    // once the next A column would meet or pass its mirrored B column.
    always_comb begin
        if (r_mode == MODE_H) begin
            w_row_wrap = ({1'b0, r_c1} + {1'b0, r_j} + (IDX_W+1)'(2)) >=
                         ({1'b0, r_c2} - {1'b0, r_j});
        end else begin
            w_row_wrap = ((r_c1 + r_j) == r_c2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_mode  <= MODE_NONE;
            r_k     <= '0;
            r_pairs <= '0;
            r_a_val <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_r1    <= r1;
                        r_r2    <= r2;
                        r_c1    <= c1;
                        r_c2    <= c2;
                        r_mode  <= flip_mode_t'(mode);
                        r_error <= 1'b0;
                    end
                end
                CHECK: begin
                    r_error <= w_arg_err;
                    r_pairs <= w_pairs;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_k     <= '0;
                end
                RD_B: r_a_val <= bram_dout;
                WR_B: begin
                    r_k <= r_k + CNT_W'(1);
                    if (w_row_wrap) begin
                        r_j <= '0;
                        r_i <= r_i + IDX_W'(1);
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = CHECK;
            end
            CHECK: begin
                w_next = (w_arg_err || (w_pairs == '0)) ? DONE : RD_A;
            end
            RD_A: begin
                bram_addr = w_addr_a;
                w_next    = RD_B;
            end
            RD_B: begin
                bram_addr = w_addr_b;
                w_next    = WR_A;
            end
            WR_A: begin
                // bram_dout now carries B's data from the RD_B read.
                bram_we   = 1'b1;
                bram_addr = w_addr_a;
                bram_din  = bram_dout;
                w_next    = WR_B;
            end
            WR_B: begin
                bram_we   = 1'b1;
                bram_addr = w_addr_b;
                bram_din  = r_a_val;
                w_next    = w_last_pair ? DONE : RD_A;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_rect_flip_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rect_flip_engine                                              |
// | Table, hand-sequence and random checks for two engine builds.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_rect_flip_engine;
    import flip_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base  = '0;
    logic [1:0] r1 = '0, r2 = '0, c1 = '0, c2 = '0, mode = '0;

    logic       busy8, done8, err8, we8;
    logic [7:0] addr8, din8, dout8;
    logic       busy4, done4, err4, we4;
    logic [3:0] addr4;
    logic [7:0] din4, dout4;

    rect_flip_engine #(.ADDR_W(8), .DATA_WIDTH(8), .ROWS(4), .COLS(4)) dut8 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base),
        .r1(r1), .r2(r2), .c1(c1), .c2(c2), .mode(mode),
        .busy(busy8), .done(done8), .error(err8), .bram_we(we8),
        .bram_addr(addr8), .bram_din(din8), .bram_dout(dout8)
    );

    rect_flip_engine #(.ADDR_W(4), .DATA_WIDTH(8), .ROWS(4), .COLS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base[3:0]),
        .r1(r1), .r2(r2), .c1(c1), .c2(c2), .mode(mode),
        .busy(busy4), .done(done4), .error(err4), .bram_we(we4),
        .bram_addr(addr4), .bram_din(din4), .bram_dout(dout4)
    );

    logic [7:0] mem8 [256];
    logic [7:0] mem4 [16];
    logic [7:0] init8 [256];
    logic [7:0] init4 [16];
    logic [7:0] exp8 [256];
    logic [7:0] exp4 [16];
    logic       init_go = 1'b0;

    always @(posedge clk) begin
        if (init_go) begin
            for (int k = 0; k < 256; k++) mem8[k] <= init8[k];
        end else if (we8) begin
            mem8[addr8] <= din8;
        end
        dout8 <= mem8[addr8];
    end

    always @(posedge clk) begin
        if (init_go) begin
            for (int k = 0; k < 16; k++) mem4[k] <= init4[k];
        end else if (we4) begin
            mem4[addr4] <= din4;
        end
        dout4 <= mem4[addr4];
    end

    int n_checks = 0;
    int n_errors = 0;
    int m_pairs;
    int m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input bit identity);
        for (int k = 0; k < 256; k++) init8[k] = identity ? 8'(k) : 8'($urandom);
        for (int k = 0; k < 16; k++)  init4[k] = identity ? 8'(k) : 8'($urandom);
        init_go = 1'b1;
        @(posedge clk); #1;
        init_go = 1'b0;
    endtask

    // Mirror model: every element of the rectangle lands on its reflection.
    task automatic model(input int b, input int a1, input int a2,
                         input int q1, input int q2, input int md);
        int moved;
        int dr;
        int dc;
        moved = 0;
        for (int k = 0; k < 256; k++) exp8[k] = mem8[k];
        for (int k = 0; k < 16; k++)  exp4[k] = mem4[k];
        m_err = ((a1 > a2) || (q1 > q2) || (a2 >= 4) || (q2 >= 4)) ? 1 : 0;
        if (m_err == 0) begin
            for (int r = a1; r <= a2; r++) begin
                for (int c = q1; c <= q2; c++) begin
                    dr = ((md & 2) != 0) ? (a1 + a2 - r) : r;
                    dc = ((md & 1) != 0) ? (q1 + q2 - c) : c;
                    if ((dr != r) || (dc != c)) moved++;
                    exp8[(b + dr*4 + dc) % 256] = mem8[(b + r*4 + c) % 256];
                    exp4[(b % 16 + dr*4 + dc) % 16] = mem4[(b % 16 + r*4 + c) % 16];
                end
            end
        end
        m_pairs = moved / 2;
    endtask

    task automatic cmp_mem(input string tag);
        int bad8;
        int bad4;
        bad8 = 0;
        bad4 = 0;
        for (int k = 0; k < 256; k++) if (mem8[k] !== exp8[k]) bad8++;
        for (int k = 0; k < 16; k++)  if (mem4[k] !== exp4[k]) bad4++;
        chk({tag, " mem8 wrong words"}, bad8, 0);
        chk({tag, " mem4 wrong words"}, bad4, 0);
    endtask

    // Issues one operation (start sampled at the end of cycle 0) and checks
    // handshake, timing, write count, error flag and final memory.
    task automatic run_op(input string tag, input logic [7:0] b,
                          input logic [1:0] a1, input logic [1:0] a2,
                          input logic [1:0] q1, input logic [1:0] q2,
                          input logic [1:0] md, input int exp_p, input int exp_e,
                          input bit noisy);
        int n;
        int w8;
        int w4;
        int busy_bad;
        int ep;
        int ee;
        int exp_cyc;
        model(int'(b), int'(a1), int'(a2), int'(q1), int'(q2), int'(md));
        ep = (exp_p < 0) ? m_pairs : exp_p;
        ee = (exp_e < 0) ? m_err : exp_e;
        exp_cyc = ((ee != 0) || (ep == 0)) ? 2 : PAIR_CYCLES * ep + 2;
        w8 = 0;
        w4 = 0;
        busy_bad = 0;
        base = b; r1 = a1; r2 = a2; c1 = q1; c2 = q2; mode = md;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done8 && n < 100) begin
            if (!busy8 || !busy4) busy_bad++;
            if (we8) w8++;
            if (we4) w4++;
            if (noisy && n >= 2 && n <= 20) begin
                start = 1'b1;
                base = 8'($urandom);
                r1 = 2'($urandom); r2 = 2'($urandom);
                c1 = 2'($urandom); c2 = 2'($urandom);
                mode = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, " done cycle"}, n, exp_cyc);
        chk({tag, " done4 aligned"}, {31'd0, done4}, 1);
        chk({tag, " busy before done"}, busy_bad, 0);
        chk({tag, " busy in done cycle"}, {31'd0, busy8}, 1);
        chk({tag, " writes8"}, w8, 2 * ep);
        chk({tag, " writes4"}, w4, 2 * ep);
        chk({tag, " error8"}, {31'd0, err8}, ee);
        chk({tag, " error4"}, {31'd0, err4}, ee);
        @(posedge clk); #1;
        chk({tag, " done pulse width"}, {31'd0, done8}, 0);
        chk({tag, " idle after done"}, {31'd0, busy8}, 0);
        chk({tag, " error held"}, {31'd0, err8}, ee);
        cmp_mem(tag);
    endtask

    typedef struct {
        logic [7:0] base;
        logic [1:0] r1, r2, c1, c2, mode;
        int         exp_p;
        int         exp_e;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'd0,  2'd0, 2'd3, 2'd0, 2'd3, 2'b01, 8, 0};
        vecs[1] = '{8'd0,  2'd1, 2'd2, 2'd0, 2'd1, 2'b10, 2, 0};
        vecs[2] = '{8'd0,  2'd0, 2'd2, 2'd0, 2'd2, 2'b11, 4, 0};
        vecs[3] = '{8'd0,  2'd2, 2'd1, 2'd0, 2'd3, 2'b01, 0, 1};
        vecs[4] = '{8'd0,  2'd0, 2'd3, 2'd0, 2'd3, 2'b00, 0, 0};
        vecs[5] = '{8'd12, 2'd0, 2'd1, 2'd0, 2'd3, 2'b01, 4, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",  {31'd0, busy8}, 0);
        chk("reset done",  {31'd0, done8}, 0);
        chk("reset error", {31'd0, err8}, 0);
        chk("reset we",    {31'd0, we8}, 0);
        chk("reset addr",  {24'd0, addr8}, 0);
        chk("reset din",   {24'd0, din8}, 0);
        chk("reset busy4", {31'd0, busy4}, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load_mem(1'b1);
            run_op($sformatf("vec%0d", v), vecs[v].base, vecs[v].r1, vecs[v].r2,
                   vecs[v].c1, vecs[v].c2, vecs[v].mode, vecs[v].exp_p, vecs[v].exp_e, 1'b0);
            case (v)
                0: for (int k = 0; k < 4; k++) begin
                    chk($sformatf("H row0 col%0d", k), {24'd0, mem8[k]}, 3 - k);
                    chk($sformatf("H row3 col%0d", k), {24'd0, mem8[12+k]}, 15 - k);
                end
                1: begin
                    chk("V mem4", {24'd0, mem8[4]}, 8);
                    chk("V mem9", {24'd0, mem8[9]}, 5);
                end
                2: begin
                    chk("Both mem0", {24'd0, mem8[0]}, 10);
                    chk("Both mem5 centre", {24'd0, mem8[5]}, 5);
                end
                5: begin
                    chk("wrap mem4[0]", {24'd0, mem4[0]}, 3);
                    chk("wrap mem4[13]", {24'd0, mem4[13]}, 14);
                end
                default: ;
            endcase
        end

        load_mem(1'b1);
        run_op("noisy start", 8'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'b01, 8, 0, 1'b1);
        chk("noisy row0 col0", {24'd0, mem8[0]}, 3);

        load_mem(1'b1);
        base = 8'd0; r1 = 2'd0; r2 = 2'd3; c1 = 2'd0; c2 = 2'd3; mode = 2'b01;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset busy", {31'd0, busy8}, 0);
        chk("midreset we", {31'd0, we8}, 0);
        chk("midreset busy4", {31'd0, busy4}, 0);
        reset = 1'b0;
        run_op("after reset", 8'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'b01, 8, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            logic [1:0] a1, a2, q1, q2, tmp;
            load_mem(1'b0);
            a1 = 2'($urandom_range(0, 3)); a2 = 2'($urandom_range(0, 3));
            q1 = 2'($urandom_range(0, 3)); q2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (a1 > a2) begin tmp = a1; a1 = a2; a2 = tmp; end
                if (q1 > q2) begin tmp = q1; q1 = q2; q2 = tmp; end
            end
            run_op($sformatf("rand%0d", t), 8'($urandom), a1, a2, q1, q2,
                   2'($urandom_range(0, 3)), -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rect_flip_engine.md
# rect_flip_engine

Parametrised in-place rectangle flip engine for matrices stored row-major in a single-port synchronous BRAM. It is the next generation of the flip controller and generalises matrix size and index width. It adds a run-time mode (horizontal mirror, vertical mirror, 180° rotation), argument validation with an error flag, and a busy/done handshake. It sits between the sequencing logic and one BRAM port.

## Interface
- `ADDR_W`, 8, BRAM address width.
- `DATA_WIDTH`, 8, element width.
- `ROWS`, 4, matrix rows.
- `COLS`, 4, matrix columns.
- `IDX_W`, `$clog2(max(ROWS,COLS))` (min 1), row/column index width.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  address of element (0,0).
- `r1`, `r2`, `c1`, `c2`  in  IDX_W each  inclusive rectangle bounds.
- `mode`  in  2  00 none, 01 horizontal, 10 vertical, 11 both (180° rotation).
- `busy`  out  1  high from the cycle after an accepted start through the done cycle.
- `done`  out  1  one-cycle pulse at completion.
- `error`  out  1  invalid arguments; valid with `done`, held until the next accepted start.
- `bram_we`  out  1  write enable.
- `bram_addr`  out  ADDR_W  address.
- `bram_din`  out  DATA_WIDTH  write data.
- `bram_dout`  in  DATA_WIDTH  read data, valid one cycle after the address.

## Operation
- On reset, every output is 0 and the state is IDLE.
- In IDLE with `start`=1, the block latches the arguments and `mode` and moves to CHECK.
- CHECK sets `error` if r1>r2, c1>c2, r2≥ROWS or c2≥COLS. It then computes h=r2-r1+1, w=c2-c1+1 and the pair count P:
  - H: P = h·⌊w/2⌋
  - V: P = ⌊h/2⌋·w
  - Both: P = ⌊h·w/2⌋
  - mode 00: P = 0
- If `error`=1 or P=0, the next state is DONE with no BRAM access. Otherwise the next state is RD_A.
- Pair enumeration uses offset counters i (row) and j (column), starting at 0:
  - H: A=(r1+i, c1+j), B=(r1+i, c2-j). j runs 0..⌊w/2⌋-1 inner; i runs 0..h-1 outer.
  - V: A=(r1+i, c1+j), B=(r2-i, c1+j). j runs 0..w-1; i runs 0..⌊h/2⌋-1.
  - Both: A=(r1+i, c1+j), B=(r2-i, c2-j). j runs 0..w-1 with i incrementing on wrap. Stop after P pairs; the centre element of an odd-sized rectangle is never touched.
- Address = base_addr + row·COLS + col, truncated modulo 2^ADDR_W (wraps silently).
- Per-pair sequence, 4 cycles:
  - RD_A: addr=A, we=0.
  - RD_B: addr=B, latch `bram_dout` as a_val.
  - WR_A: addr=A, we=1, din=`bram_dout` (B's data).
  - WR_B: addr=B, we=1, din=a_val.
- After WR_B, go to RD_A for the next pair, or to DONE after pair P.
- DONE asserts `done`=1 for one cycle, then returns to IDLE.
- `start` while busy is ignored and its arguments are not latched.
- Reset mid-operation returns to IDLE the next cycle with `bram_we`=0. Any partially swapped memory is left as is.

## Timing
- If start is sampled in cycle 0: CHECK is cycle 1, pair k (0-based) occupies cycles 2+4k..5+4k, and `done` is in cycle 4P+2.
- For error or P=0, `done` is in cycle 2.
- `bram_we` is high only in WR_A and WR_B, giving exactly 2P writes per operation.
- Back-to-back operation: start may be re-asserted in the cycle after `done`.

## Structure
- Package `flip_pkg` holds:
  - the `flip_mode_t` enum (MODE_NONE, MODE_H, MODE_V, MODE_BOTH);
  - the `flip_state_t` enum (IDLE, CHECK, RD_A, RD_B, WR_A, WR_B, DONE);
  - the per-pair cycle constant (4).
- Sub-module `flip_addr_gen`: combinational computation of the A and B addresses from the latched bounds, mode, i and j.
- Top level: FSM, counters, a_val register, output registers.

## Test plan
Defaults: ROWS=COLS=4, base=0, mem[k]=k.
1. H, r=0..3, c=0..3 -> P=8, `done` at cycle 34, row 0 reads 3,2,1,0 and row 3 reads 15,14,13,12.
2. V, r=1..2, c=0..1 -> mem[4]↔mem[8], mem[5]↔mem[9], `done` at cycle 10, 4 writes, all else unchanged.
3. Both, r=0..2, c=0..2 -> P=4, mem[0]↔mem[10], mem[1]↔mem[9], mem[2]↔mem[8], mem[4]↔mem[6], mem[5] unchanged.
4. r1=2, r2=1 (any mode), and separately mode 00 -> `done` at cycle 2; `error`=1 only for the invalid case; `bram_we` never high.
5. Start re-asserted during busy -> ignored, result identical to test 1. Reset at cycle 5 -> next cycle busy=0, bram_we=0; a fresh start then completes normally.
6. ADDR_W=4, base=12, H on r=0..1, c=0..3 -> row 1 addresses wrap to 0..3; mem[0]↔mem[3], mem[1]↔mem[2], mem[12]↔mem[15], mem[13]↔mem[14].
